marker_track: RTL and testbench

MARKER_TRACK -- requirements
Module: marker_track

---
 rtl/marker_track.sv | 224 ++++++++++++++++++++++
 tb/tb_marker_track.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/marker_track.sv
// Tracks the tallest vertical run of row detections per frame and publishes its centre after frame start.
// Optional MARKER_TRACK_ROWS_EN adds marker_rows_out carrying the winning run height.
module marker_track #(
    parameter int unsigned X_TOL      = 16,
    parameter int unsigned PROB_THRES = 40,
    parameter int unsigned MIN_ROWS   = 4,
    parameter int unsigned MAX_GAP    = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        frame_start_in,
    input  logic [9:0]  vcount_in,
    input  logic        detect_in,
    input  logic [10:0] coord_in,
    input  logic [10:0] prob_in,
    output logic        marker_valid_out,
    output logic        marker_found_out,
    output logic [10:0] marker_x_out,
    output logic [9:0]  marker_y_out
`ifdef MARKER_TRACK_ROWS_EN
    ,
    output logic [9:0]  marker_rows_out
`endif
);

    localparam int unsigned XW = 11;
    localparam int unsigned YW = 10;
    localparam int unsigned RW = 11;

    localparam logic [XW-1:0] X_TOL_C = XW'(X_TOL);
    localparam logic [XW-1:0] PROB_C  = XW'(PROB_THRES);
    localparam logic [RW-1:0] MIN_C   = RW'(MIN_ROWS);
    localparam logic [RW-1:0] GAP_C   = RW'(MAX_GAP);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_TRACK   = 2'd1,
        S_PUBLISH = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [XW-1:0]   anchor_q, anchor_d;
    logic [XW-1:0]   x_min_q, x_min_d;
    logic [XW-1:0]   x_max_q, x_max_d;
    logic [YW-1:0]   y_start_q, y_start_d;
    logic [YW-1:0]   y_last_q, y_last_d;
    logic [XW-1:0]   best_x_q, best_x_d;
    logic [YW-1:0]   best_y_q, best_y_d;
    logic [RW-1:0]   best_rows_q, best_rows_d;
    logic            best_found_q, best_found_d;
    logic            valid_q, valid_d;
    logic            found_q, found_d;
    logic [XW-1:0]   x_q, x_d;
    logic [YW-1:0]   y_q, y_d;
`ifdef MARKER_TRACK_ROWS_EN
    logic [YW-1:0]   rows_q, rows_d;
`endif

    logic            accept_c;
    logic [XW-1:0]   coord_diff_c;
    logic            in_tol_c;
    logic            gap_close_c;
    logic [RW-1:0]   cand_rows_c;
    logic            cand_wins_c;
    logic [XW:0]     x_sum_c;
    logic [YW:0]     y_sum_c;
    logic [XW-1:0]   cand_x_c;
    logic [YW-1:0]   cand_y_c;
    logic            mrg_found_c;
    logic [XW-1:0]   mrg_x_c;
    logic [YW-1:0]   mrg_y_c;
    logic [RW-1:0]   mrg_rows_c;

    // Detection qualification and distance to the running anchor, ordered to avoid underflow
    assign accept_c     = detect_in && (prob_in <= PROB_C);
    assign coord_diff_c = (coord_in >= anchor_q) ? (coord_in - anchor_q) : (anchor_q - coord_in);
    assign in_tol_c     = (coord_diff_c < X_TOL_C);
    assign gap_close_c  = ({1'b0, vcount_in} > ({1'b0, y_last_q} + GAP_C));

    // Result of closing the open candidate against the current best; ties keep the earlier best
    assign cand_rows_c  = {1'b0, y_last_q} - {1'b0, y_start_q} + RW'(1);
    assign cand_wins_c  = (cand_rows_c >= MIN_C) && (cand_rows_c > best_rows_q);
    assign x_sum_c      = {1'b0, x_min_q} + {1'b0, x_max_q};
    assign y_sum_c      = {1'b0, y_start_q} + {1'b0, y_last_q};
    assign cand_x_c     = XW'(x_sum_c >> 1);
    assign cand_y_c     = YW'(y_sum_c >> 1);
    assign mrg_found_c  = cand_wins_c ? 1'b1        : best_found_q;
    assign mrg_x_c      = cand_wins_c ? cand_x_c    : best_x_q;
    assign mrg_y_c      = cand_wins_c ? cand_y_c    : best_y_q;
    assign mrg_rows_c   = cand_wins_c ? cand_rows_c : best_rows_q;

    // Next-state and register updates
    always_comb begin
        state_d      = state_q;
        anchor_d     = anchor_q;
        x_min_d      = x_min_q;
        x_max_d      = x_max_q;
        y_start_d    = y_start_q;
        y_last_d     = y_last_q;
        best_x_d     = best_x_q;
        best_y_d     = best_y_q;
        best_rows_d  = best_rows_q;
        best_found_d = best_found_q;
        valid_d      = 1'b0;
        found_d      = found_q;
        x_d          = x_q;
        y_d          = y_q;
`ifdef MARKER_TRACK_ROWS_EN
        rows_d       = rows_q;
`endif

        if (frame_start_in) begin
            // Publish the frame result (folding in any open candidate) and start the next frame empty
            state_d = S_PUBLISH;
            valid_d = 1'b1;
            if (state_q == S_TRACK) begin
                found_d = mrg_found_c;
                x_d     = mrg_x_c;
                y_d     = mrg_y_c;
`ifdef MARKER_TRACK_ROWS_EN
                rows_d  = YW'(mrg_rows_c);
`endif
            end else begin
                found_d = best_found_q;
                x_d     = best_x_q;
                y_d     = best_y_q;
`ifdef MARKER_TRACK_ROWS_EN
                rows_d  = YW'(best_rows_q);
`endif
            end
            best_x_d     = '0;
            best_y_d     = '0;
            best_rows_d  = '0;
            best_found_d = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (accept_c) begin
                        state_d   = S_TRACK;
                        anchor_d  = coord_in;
                        x_min_d   = coord_in;
                        x_max_d   = coord_in;
                        y_start_d = vcount_in;
                        y_last_d  = vcount_in;
                    end
                end
                S_TRACK: begin
                    if (gap_close_c) begin
                        // Any detection in this cycle is dropped with the closing candidate
                        state_d      = S_IDLE;
                        best_found_d = mrg_found_c;
                        best_x_d     = mrg_x_c;
                        best_y_d     = mrg_y_c;
                        best_rows_d  = mrg_rows_c;
                    end else if (accept_c && in_tol_c) begin
                        anchor_d = coord_in;
                        y_last_d = vcount_in;
                        if (coord_in < x_min_q) begin
                            x_min_d = coord_in;
                        end
                        if (coord_in > x_max_q) begin
                            x_max_d = coord_in;
                        end
                    end
                end
                S_PUBLISH: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q      <= S_IDLE;
            anchor_q     <= '0;
            x_min_q      <= '0;
            x_max_q      <= '0;
            y_start_q    <= '0;
            y_last_q     <= '0;
            best_x_q     <= '0;
            best_y_q     <= '0;
            best_rows_q  <= '0;
            best_found_q <= 1'b0;
            valid_q      <= 1'b0;
            found_q      <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
`ifdef MARKER_TRACK_ROWS_EN
            rows_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            anchor_q     <= anchor_d;
            x_min_q      <= x_min_d;
            x_max_q      <= x_max_d;
            y_start_q    <= y_start_d;
            y_last_q     <= y_last_d;
            best_x_q     <= best_x_d;
            best_y_q     <= best_y_d;
            best_rows_q  <= best_rows_d;
            best_found_q <= best_found_d;
            valid_q      <= valid_d;
            found_q      <= found_d;
            x_q          <= x_d;
            y_q          <= y_d;
`ifdef MARKER_TRACK_ROWS_EN
            rows_q       <= rows_d;
`endif
        end
    end

    assign marker_valid_out = valid_q;
    assign marker_found_out = found_q;
    assign marker_x_out     = x_q;
    assign marker_y_out     = y_q;
`ifdef MARKER_TRACK_ROWS_EN
    assign marker_rows_out  = rows_q;
`endif

endmodule

// File: tb/tb_marker_track.sv
// Bench for marker_track: directed frames plus random frames checked against a run-level reference model.
module tb_marker_track;

    localparam int X_TOL      = 16;
    localparam int PROB_THRES = 40;
    localparam int MIN_ROWS   = 4;
    localparam int MAX_GAP    = 2;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        frame_start_in;
    logic [9:0]  vcount_in;
    logic        detect_in;
    logic [10:0] coord_in;
    logic [10:0] prob_in;
    logic        marker_valid_out;
    logic        marker_found_out;
    logic [10:0] marker_x_out;
    logic [9:0]  marker_y_out;
`ifdef MARKER_TRACK_ROWS_EN
    logic [9:0]  marker_rows_out;
`endif

    marker_track #(
        .X_TOL      (X_TOL),
        .PROB_THRES (PROB_THRES),
        .MIN_ROWS   (MIN_ROWS),
        .MAX_GAP    (MAX_GAP)
    ) dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .frame_start_in   (frame_start_in),
        .vcount_in        (vcount_in),
        .detect_in        (detect_in),
        .coord_in         (coord_in),
        .prob_in          (prob_in),
        .marker_valid_out (marker_valid_out),
        .marker_found_out (marker_found_out),
        .marker_x_out     (marker_x_out),
        .marker_y_out     (marker_y_out)
`ifdef MARKER_TRACK_ROWS_EN
        ,
        .marker_rows_out  (marker_rows_out)
`endif
    );

    always #5 clk_in = ~clk_in;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: one open run plus the frame's best run
    int m_open, m_anchor, m_xmin, m_xmax, m_ys, m_yl;
    int b_found, b_x, b_y, b_rows;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_in);
        #1;
    endtask

    task automatic m_reset();
        m_open = 0; m_anchor = 0; m_xmin = 0; m_xmax = 0; m_ys = 0; m_yl = 0;
        b_found = 0; b_x = 0; b_y = 0; b_rows = 0;
    endtask

    task automatic m_close();
        int rows;
        if (m_open != 0) begin
            rows = m_yl - m_ys + 1;
            if (rows >= MIN_ROWS && rows > b_rows) begin
                b_found = 1;
                b_x     = (m_xmin + m_xmax) / 2;
                b_y     = (m_ys + m_yl) / 2;
                b_rows  = rows;
            end
            m_open = 0;
        end
    endtask

    task automatic m_row(input int r, input bit det, input int c, input int p, input bit early);
        bit closed;
        int d;
        closed = 0;
        if (m_open != 0 && r > m_yl + MAX_GAP) begin
            m_close();
            closed = 1;
        end
        if (det && p <= PROB_THRES && !(closed && early)) begin
            if (m_open == 0) begin
                m_open = 1; m_anchor = c; m_xmin = c; m_xmax = c; m_ys = r; m_yl = r;
            end else begin
                d = (c > m_anchor) ? c - m_anchor : m_anchor - c;
                if (d < X_TOL) begin
                    m_anchor = c;
                    if (c < m_xmin) m_xmin = c;
                    if (c > m_xmax) m_xmax = c;
                    m_yl = r;
                end
            end
        end
    endtask

    // One row = three cycles; the detection pulse lands on the first (early) or second cycle
    task automatic do_row(input int r, input bit det, input int c, input int p, input bit early);
        m_row(r, det, c, p, early);
        vcount_in = 10'(r);
        coord_in  = 11'(c);
        prob_in   = 11'(p);
        detect_in = det && early;
        cyc();
        detect_in = det && !early;
        cyc();
        detect_in = 1'b0;
        cyc();
    endtask

    task automatic publish(input string tag);
        int ef, ex, ey, er;
        m_close();
        ef = b_found; ex = b_x; ey = b_y; er = b_rows;
        b_found = 0; b_x = 0; b_y = 0; b_rows = 0;
        frame_start_in = 1'b1;
        detect_in      = 1'b0;
        vcount_in      = '0;
        cyc();
        chk({tag, ".valid"}, 32'(marker_valid_out), 32'(1));
        chk({tag, ".found"}, 32'(marker_found_out), 32'(ef));
        chk({tag, ".x"},     32'(marker_x_out),     32'(ex));
        chk({tag, ".y"},     32'(marker_y_out),     32'(ey));
`ifdef MARKER_TRACK_ROWS_EN
        chk({tag, ".rows"},  32'(marker_rows_out),  32'(er));
`else
        er = er;
`endif
        frame_start_in = 1'b0;
        cyc();
        chk({tag, ".valid_drop"}, 32'(marker_valid_out), 32'(0));
        chk({tag, ".found_hold"}, 32'(marker_found_out), 32'(ef));
        chk({tag, ".x_hold"},     32'(marker_x_out),     32'(ex));
    endtask

    initial begin
        int r, base, c, nrows;
        rst_in = 1'b1; frame_start_in = 1'b0; vcount_in = '0;
        detect_in = 1'b0; coord_in = '0; prob_in = '0;
        m_reset();
        #1;
        chk("por.valid", 32'(marker_valid_out), 32'(0));
        chk("por.found", 32'(marker_found_out), 32'(0));
        chk("por.x",     32'(marker_x_out),     32'(0));
        chk("por.y",     32'(marker_y_out),     32'(0));
        cyc(); cyc();
        rst_in = 1'b0;
        cyc();

        // Ten-row run at x=300
        for (int i = 100; i <= 109; i++) do_row(i, 1, 300, 10, 0);
        publish("ten_rows");
        chk("ten_rows.x_spec", 32'(marker_x_out), 32'(300));
        chk("ten_rows.y_spec", 32'(marker_y_out), 32'(104));

        // Three rows are too short
        for (int i = 50; i <= 52; i++) do_row(i, 1, 300, 10, 0);
        publish("short_run");
        chk("short_run.found_spec", 32'(marker_found_out), 32'(0));

        // Off-tolerance detections do not join
        for (int i = 10; i <= 14; i++) do_row(i, 1, 200, 5, 0);
        for (int i = 15; i <= 17; i++) do_row(i, 1, 260, 5, 0);
        do_row(18, 0, 0, 0, 0);
        publish("x_tol");
        chk("x_tol.x_spec", 32'(marker_x_out), 32'(200));
        chk("x_tol.y_spec", 32'(marker_y_out), 32'(12));

        // Taller later run wins
        for (int i = 20; i <= 25; i++) do_row(i, 1, 100, 5, 0);
        for (int i = 40; i <= 49; i++) do_row(i, 1, 500, 5, 0);
        publish("two_runs");
        chk("two_runs.x_spec", 32'(marker_x_out), 32'(500));
        chk("two_runs.y_spec", 32'(marker_y_out), 32'(44));

        // Asynchronous reset mid-run drops the candidate and held outputs
        for (int i = 60; i <= 62; i++) do_row(i, 1, 300, 10, 0);
        #2 rst_in = 1'b1;
        #1;
        m_reset();
        chk("rst.found", 32'(marker_found_out), 32'(0));
        chk("rst.x",     32'(marker_x_out),     32'(0));
        chk("rst.y",     32'(marker_y_out),     32'(0));
        chk("rst.valid", 32'(marker_valid_out), 32'(0));
        cyc();
        rst_in = 1'b0;
        for (int i = 63; i <= 65; i++) do_row(i, 1, 300, 10, 0);
        chk("rst.no_publish", 32'(marker_valid_out), 32'(0));
        publish("after_rst");
        chk("after_rst.found_spec", 32'(marker_found_out), 32'(0));

        // Probability just above threshold is rejected
        for (int i = 0; i <= 20; i++) do_row(i, 1, 300, 41, 0);
        publish("prob41");
        chk("prob41.found_spec", 32'(marker_found_out), 32'(0));

        // Back-to-back frame starts: second publish is empty
        for (int i = 100; i <= 109; i++) do_row(i, 1, 700, 40, 0);
        m_close();
        frame_start_in = 1'b1;
        cyc();
        chk("rep.valid1", 32'(marker_valid_out), 32'(1));
        chk("rep.found1", 32'(marker_found_out), 32'(1));
        chk("rep.x1",     32'(marker_x_out),     32'(700));
        chk("rep.y1",     32'(marker_y_out),     32'(104));
        cyc();
        chk("rep.valid2", 32'(marker_valid_out), 32'(1));
        chk("rep.found2", 32'(marker_found_out), 32'(0));
        frame_start_in = 1'b0;
        m_reset();
        cyc();
        chk("rep.valid3", 32'(marker_valid_out), 32'(0));

        // Detection in the gap-closing cycle is lost, and the resulting tie keeps the first run
        for (int i = 10; i <= 14; i++) do_row(i, 1, 200, 5, 0);
        do_row(20, 1, 400, 5, 1);
        for (int i = 21; i <= 25; i++) do_row(i, 1, 400, 5, 0);
        publish("lost_det");
        chk("lost_det.x_spec", 32'(marker_x_out), 32'(200));
        chk("lost_det.y_spec", 32'(marker_y_out), 32'(12));

        // Random frames against the model
        for (int f = 0; f < 24; f++) begin
            r     = int'($urandom_range(1, 5));
            base  = int'($urandom_range(100, 1900));
            nrows = 0;
            while (nrows < 40) begin
                if ($urandom_range(0, 9) == 0) base = int'($urandom_range(100, 1900));
                c = base + int'($urandom_range(0, 30)) - 15;
                do_row(r, $urandom_range(0, 3) != 0, c, int'($urandom_range(0, 55)),
                       $urandom_range(0, 3) == 0);
                r += int'($urandom_range(1, 4));
                nrows++;
            end
            publish($sformatf("rand%0d", f));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
